// File: rtl/clusterv_memc_pkg.sv
// Shared definitions for the clusterv main-SRAM Wishbone controller.
// Holds the FSM state encoding, the sky130 1 KiB macro geometry and the
// bank-index width helper used by the controller and its read mux.
package clusterv_memc_pkg;

  localparam int SRAM_WORDS  = 256;
  localparam int SRAM_ADR_W  = 8;
  localparam int SRAM_DAT_W  = 32;
  localparam int SRAM_MASK_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Width of the bank field in the address; a single bank still takes one
  // bit so that address bit 10 can flag an out-of-range access.
  function automatic int bank_w(input int n_banks);
    int w;
    w = $clog2(n_banks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clusterv_memc_rdmux.sv
// Purpose: selects one bank's 32-bit read data out of the concatenated macro outputs.
// Latency: combinational, zero cycles.
// Backpressure: none; pure data path.
// Ports: sram_dout (all banks, bank b on [32*b+:32]), bank (index), rd_dat (selected word).
module clusterv_memc_rdmux
  import clusterv_memc_pkg::*;
#(
  parameter int N_BANKS = 4,
  parameter int BW      = bank_w(N_BANKS)
) (
  input  logic [SRAM_DAT_W*N_BANKS-1:0] sram_dout,
  input  logic [BW-1:0]                 bank,
  output logic [SRAM_DAT_W-1:0]         rd_dat
);

  always_comb begin
    rd_dat = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (32'(bank) == b) begin
        rd_dat = sram_dout[SRAM_DAT_W*b +: SRAM_DAT_W];
      end
    end
  end

endmodule

// File: rtl/clusterv_memc.sv
// Purpose: Wishbone classic target sequencing single accesses onto a bank of 32x256 SRAM macros (port 0).
// Latency: write ack in cycle 2, read ack in cycle 2+READ_LAT, out-of-range error in cycle 1.
// Backpressure: one access in flight; requests are only sampled in IDLE, so stb is held off until ack/err.
// Ports: clock/reset (sync, active-high); t_* Wishbone target side; sram_* shared macro
//        controls plus per-bank active-low chip selects; sram_dout is every bank's read data.
module clusterv_memc
  import clusterv_memc_pkg::*;
#(
  parameter int N_BANKS  = 4,
  parameter int READ_LAT = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   t_adr,
  input  logic [SRAM_DAT_W-1:0]         t_dat_w,
  output logic [SRAM_DAT_W-1:0]         t_dat_r,
  input  logic                          t_cyc,
  input  logic                          t_stb,
  input  logic                          t_we,
  input  logic [SRAM_MASK_W-1:0]        t_sel,
  output logic                          t_ack,
  output logic                          t_err,
  output logic [N_BANKS-1:0]            sram_csb,
  output logic                          sram_web,
  output logic [SRAM_MASK_W-1:0]        sram_wmask,
  output logic [SRAM_ADR_W-1:0]         sram_addr,
  output logic [SRAM_DAT_W-1:0]         sram_din,
  input  logic [SRAM_DAT_W*N_BANKS-1:0] sram_dout
);

  localparam int BW       = bank_w(N_BANKS);
  localparam int WORD_LSB = 2;
  localparam int BANK_LSB = WORD_LSB + $clog2(SRAM_WORDS);
  localparam logic [1:0] LAT_INIT = 2'(READ_LAT);

  state_e                  state_q, state_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic                    we_q, we_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [N_BANKS-1:0]      csb_q, csb_d;
  logic                    web_q, web_d;
  logic [SRAM_MASK_W-1:0]  wmask_q, wmask_d;
  logic [SRAM_ADR_W-1:0]   addr_q, addr_d;
  logic [SRAM_DAT_W-1:0]   din_q, din_d;
  logic [SRAM_DAT_W-1:0]   dat_r_q, dat_r_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic [BW-1:0]           req_bank;
  logic                    req_ok;
  logic [SRAM_DAT_W-1:0]   rd_dat;
  logic                    unused_adr;

  assign req_bank   = t_adr[BANK_LSB+BW-1:BANK_LSB];
  assign req_ok     = (32'(req_bank) < N_BANKS);
  assign unused_adr = ^{t_adr[31:BANK_LSB+BW], t_adr[WORD_LSB-1:0]};

  clusterv_memc_rdmux #(
    .N_BANKS (N_BANKS),
    .BW      (BW)
  ) u_rdmux (
    .sram_dout (sram_dout),
    .bank      (bank_q),
    .rd_dat    (rd_dat)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    csb_d   = '1;          // chip select is a one-cycle pulse by construction
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dat_r_d = dat_r_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (t_cyc && t_stb) begin
          if (!req_ok) begin
            err_d   = t_cyc;
            state_d = ST_ERR;
          end else begin
            addr_d  = t_adr[BANK_LSB-1:WORD_LSB];
            din_d   = t_dat_w;
            wmask_d = t_we ? t_sel : '0;
            web_d   = ~t_we;
            for (int b = 0; b < N_BANKS; b++) begin
              if (32'(req_bank) == b) csb_d[b] = 1'b0;
            end
            bank_d  = req_bank;
            we_d    = t_we;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          ack_d   = t_cyc;     // a dropped cycle still finishes, just silently
          state_d = ST_ACK;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          dat_r_d = rd_dat;
          ack_d   = t_cyc;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dat_r_q <= dat_r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign t_dat_r    = dat_r_q;
  assign t_ack      = ack_q;
  assign t_err      = err_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;

endmodule

// File: tb/tb_clusterv_memc.sv
// Bench for clusterv_memc: instance A (4 banks, READ_LAT=1) and instance B
// (3 banks, READ_LAT=3), each attached to a behavioural 1-cycle SRAM bank model.
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
module tb_clusterv_memc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A signals
  logic [31:0] a_adr = '0, a_dat_w = '0, a_dat_r, a_addr_w, a_din;
  logic a_cyc = 0, a_stb = 0, a_we = 0, a_ack, a_err, a_web;
  logic [3:0] a_sel = '0, a_csb, a_wmask;
  logic [7:0] a_addr;
  logic [127:0] a_dout;
  // Instance B signals
  logic [31:0] b_adr = '0, b_dat_w = '0, b_dat_r, b_din;
  logic b_cyc = 0, b_stb = 0, b_we = 0, b_ack, b_err, b_web;
  logic [3:0] b_sel = '0, b_wmask;
  logic [2:0] b_csb;
  logic [7:0] b_addr;
  logic [95:0] b_dout;

  clusterv_memc #(.N_BANKS(4), .READ_LAT(1)) dut_a (
    .clock(clk), .reset(rst), .t_adr(a_adr), .t_dat_w(a_dat_w), .t_dat_r(a_dat_r),
    .t_cyc(a_cyc), .t_stb(a_stb), .t_we(a_we), .t_sel(a_sel), .t_ack(a_ack), .t_err(a_err),
    .sram_csb(a_csb), .sram_web(a_web), .sram_wmask(a_wmask), .sram_addr(a_addr),
    .sram_din(a_din), .sram_dout(a_dout));

  clusterv_memc #(.N_BANKS(3), .READ_LAT(3)) dut_b (
    .clock(clk), .reset(rst), .t_adr(b_adr), .t_dat_w(b_dat_w), .t_dat_r(b_dat_r),
    .t_cyc(b_cyc), .t_stb(b_stb), .t_we(b_we), .t_sel(b_sel), .t_ack(b_ack), .t_err(b_err),
    .sram_csb(b_csb), .sram_web(b_web), .sram_wmask(b_wmask), .sram_addr(b_addr),
    .sram_din(b_din), .sram_dout(b_dout));

  assign a_addr_w = {24'h0, a_addr};

  // Macro models: preload pattern A0bb_00ww, read data appears the cycle after csb low.
  function automatic logic [31:0] pat(input int b, input int w);
    return 32'hA000_0000 | (32'(b) << 16) | 32'(w);
  endfunction

  logic [31:0] mem_a [4][256];
  logic [31:0] rd_a [4];
  logic [31:0] mem_b [3][256];
  logic [31:0] rd_b [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < 4; b++) for (int w = 0; w < 256; w++) mem_a[b][w] <= pat(b, w);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!a_csb[b]) begin
          if (!a_web) begin
            for (int k = 0; k < 4; k++) if (a_wmask[k]) mem_a[b][a_addr][8*k +: 8] <= a_din[8*k +: 8];
          end else begin
            rd_a[b] <= mem_a[b][a_addr];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < 3; b++) for (int w = 0; w < 256; w++) mem_b[b][w] <= pat(b, w);
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (!b_csb[b]) begin
          if (!b_web) begin
            for (int k = 0; k < 4; k++) if (b_wmask[k]) mem_b[b][b_addr][8*k +: 8] <= b_din[8*k +: 8];
          end else begin
            rd_b[b] <= mem_b[b][b_addr];
          end
        end
      end
    end
  end

  assign a_dout = {rd_a[3], rd_a[2], rd_a[1], rd_a[0]};
  assign b_dout = {rd_b[2], rd_b[1], rd_b[0]};

  // Observations of the last transfer
  int obs_ack, obs_err, obs_lows, obs_maxrun, obs_csb_cyc, obs_stray;
  logic [3:0] obs_csb, obs_wmask;
  logic [7:0] obs_addr;
  logic obs_web, obs_early;
  logic [31:0] obs_din, obs_rd, obs_dat0;

  task automatic a_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    int run;
    @(posedge clk); #1;
    a_cyc = 1; a_stb = 1; a_we = we; a_adr = adr; a_dat_w = wd; a_sel = sel;
    obs_ack = -1; obs_err = -1; obs_lows = 0; obs_maxrun = 0; obs_csb_cyc = -1; obs_csb = 4'hF; run = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_csb != 4'hF) begin
        obs_lows++; run++;
        if (obs_csb_cyc < 0) begin
          obs_csb_cyc = c; obs_csb = a_csb; obs_addr = a_addr; obs_web = a_web;
          obs_wmask = a_wmask; obs_din = a_din;
        end
      end else run = 0;
      if (run > obs_maxrun) obs_maxrun = run;
      if (a_err) begin obs_err = c; break; end
      if (a_ack) begin obs_ack = c; obs_rd = a_dat_r; break; end
    end
  endtask

  task automatic b_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    @(posedge clk); #1;
    b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_dat_w = wd; b_sel = sel;
    obs_ack = -1; obs_err = -1; obs_lows = 0; obs_csb_cyc = -1; obs_csb = 4'hF; obs_early = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) obs_dat0 = b_dat_r;
      if (b_csb != 3'b111) begin
        obs_lows++;
        if (obs_csb_cyc < 0) begin obs_csb_cyc = c; obs_csb = {1'b1, b_csb}; end
      end
      if (b_err) begin obs_err = c; break; end
      if (b_ack) begin obs_ack = c; obs_rd = b_dat_r; break; end
      if (b_dat_r !== obs_dat0) obs_early = 1;
    end
  endtask

  task automatic a_idle(input int n);
    @(posedge clk); #1;
    a_cyc = 0; a_stb = 0; a_we = 0;
    obs_stray = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (a_ack || a_err || a_csb != 4'hF) obs_stray++;
    end
  endtask

  task automatic b_idle(input int n);
    @(posedge clk); #1;
    b_cyc = 0; b_stb = 0; b_we = 0;
    obs_stray = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (b_ack || b_err || b_csb != 3'b111) obs_stray++;
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_init = 1;
    repeat (3) @(posedge clk);
    #1; rst = 0; mem_init = 0;
    @(negedge clk);
    checks++; if (a_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b want=0", a_ack); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b want=0", a_err); end
    checks++; if (a_dat_r !== 32'h0) begin failures++; $display("FAIL rst_dat_r got=%0h want=0", a_dat_r); end
    checks++; if (a_csb !== 4'hF) begin failures++; $display("FAIL rst_csb got=%0h want=f", a_csb); end
    checks++; if (a_web !== 1'b1) begin failures++; $display("FAIL rst_web got=%0b want=1", a_web); end
    checks++; if (a_wmask !== 4'h0) begin failures++; $display("FAIL rst_wmask got=%0h want=0", a_wmask); end
    checks++; if (a_addr_w !== 32'h0) begin failures++; $display("FAIL rst_addr got=%0h want=0", a_addr); end
    checks++; if (a_din !== 32'h0) begin failures++; $display("FAIL rst_din got=%0h want=0", a_din); end
    checks++; if (b_csb !== 3'b111) begin failures++; $display("FAIL rst_b_csb got=%0b want=111", b_csb); end
  endtask

  task automatic test_write_read();
    a_xfer(1, 32'h8000_0404, 32'hDEAD_BEEF, 4'hF);
    checks++; if (obs_csb_cyc !== 1) begin failures++; $display("FAIL wr_csb_cycle got=%0d want=1", obs_csb_cyc); end
    checks++; if (obs_csb !== 4'b1101) begin failures++; $display("FAIL wr_csb got=%0b want=1101", obs_csb); end
    checks++; if (obs_addr !== 8'h01) begin failures++; $display("FAIL wr_addr got=%0h want=01", obs_addr); end
    checks++; if (obs_web !== 1'b0) begin failures++; $display("FAIL wr_web got=%0b want=0", obs_web); end
    checks++; if (obs_wmask !== 4'hF) begin failures++; $display("FAIL wr_wmask got=%0h want=f", obs_wmask); end
    checks++; if (obs_din !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_din got=%0h want=deadbeef", obs_din); end
    checks++; if (obs_ack !== 2) begin failures++; $display("FAIL wr_ack_cycle got=%0d want=2", obs_ack); end
    checks++; if (obs_lows !== 1) begin failures++; $display("FAIL wr_csb_lows got=%0d want=1", obs_lows); end
    a_idle(1);
    a_xfer(0, 32'h8000_0404, 32'h0, 4'hF);
    checks++; if (obs_ack !== 3) begin failures++; $display("FAIL rd_ack_cycle got=%0d want=3", obs_ack); end
    checks++; if (obs_rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%0h want=deadbeef", obs_rd); end
    checks++; if (obs_csb !== 4'b1101) begin failures++; $display("FAIL rd_csb got=%0b want=1101", obs_csb); end
    checks++; if (obs_web !== 1'b1) begin failures++; $display("FAIL rd_web got=%0b want=1", obs_web); end
    checks++; if (obs_wmask !== 4'h0) begin failures++; $display("FAIL rd_wmask got=%0h want=0", obs_wmask); end
    a_idle(1);
  endtask

  task automatic test_byte_write();
    a_xfer(1, 32'h8000_0000, 32'h1122_3344, 4'hF);
    a_xfer(1, 32'h8000_0000, 32'h00AA_0000, 4'b0100);
    checks++; if (obs_wmask !== 4'b0100) begin failures++; $display("FAIL bw_wmask got=%0b want=0100", obs_wmask); end
    a_xfer(0, 32'h8000_0000, 32'h0, 4'hF);
    checks++; if (obs_rd !== 32'h11AA_3344) begin failures++; $display("FAIL bw_read got=%0h want=11aa3344", obs_rd); end
    a_xfer(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0);
    checks++; if (obs_wmask !== 4'h0) begin failures++; $display("FAIL sel0_wmask got=%0h want=0", obs_wmask); end
    checks++; if (obs_ack !== 2) begin failures++; $display("FAIL sel0_ack_cycle got=%0d want=2", obs_ack); end
    a_xfer(0, 32'h8000_0000, 32'h0, 4'hF);
    checks++; if (obs_rd !== 32'h11AA_3344) begin failures++; $display("FAIL sel0_read got=%0h want=11aa3344", obs_rd); end
    a_idle(1);
  endtask

  task automatic test_err_bank();
    b_xfer(0, 32'h8000_0C00, 32'h0, 4'hF);
    checks++; if (obs_err !== 1) begin failures++; $display("FAIL err_cycle got=%0d want=1", obs_err); end
    checks++; if (obs_lows !== 0) begin failures++; $display("FAIL err_csb_lows got=%0d want=0", obs_lows); end
    checks++; if (obs_ack !== -1) begin failures++; $display("FAIL err_ack got=%0d want=-1", obs_ack); end
    b_idle(4);
    checks++; if (obs_stray !== 0) begin failures++; $display("FAIL err_after got=%0d want=0", obs_stray); end
    checks++; if (b_dat_r !== 32'h0) begin failures++; $display("FAIL err_dat_r got=%0h want=0", b_dat_r); end
  endtask

  task automatic test_read_lat3();
    b_xfer(0, 32'h8000_0800, 32'h0, 4'hF);
    checks++; if (obs_csb !== 4'b1011) begin failures++; $display("FAIL l3_b2_csb got=%0b want=1011", obs_csb); end
    checks++; if (obs_ack !== 5) begin failures++; $display("FAIL l3_b2_ack_cycle got=%0d want=5", obs_ack); end
    checks++; if (obs_rd !== 32'hA002_0000) begin failures++; $display("FAIL l3_b2_data got=%0h want=a0020000", obs_rd); end
    b_idle(1);
    b_xfer(0, 32'h8000_03FC, 32'h0, 4'hF);
    checks++; if (obs_dat0 !== 32'hA002_0000) begin failures++; $display("FAIL l3_hold_start got=%0h want=a0020000", obs_dat0); end
    checks++; if (obs_early !== 1'b0) begin failures++; $display("FAIL l3_hold_early got=%0b want=0", obs_early); end
    checks++; if (obs_ack !== 5) begin failures++; $display("FAIL l3_ack_cycle got=%0d want=5", obs_ack); end
    checks++; if (obs_rd !== 32'hA000_00FF) begin failures++; $display("FAIL l3_data got=%0h want=a00000ff", obs_rd); end
    b_idle(1);
  endtask

  task automatic test_abort_cyc();
    int lows, acks;
    lows = 0; acks = 0;
    @(posedge clk); #1;
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 32'h8000_0808; a_sel = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_csb != 4'hF) lows++;
      if (a_ack) acks++;
      if (c == 1) begin @(posedge clk); #1; a_cyc = 0; a_stb = 0; end
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL abort_ack got=%0d want=0", acks); end
    checks++; if (lows !== 1) begin failures++; $display("FAIL abort_csb_lows got=%0d want=1", lows); end
    a_xfer(0, 32'h8000_0808, 32'h0, 4'hF);
    checks++; if (obs_ack !== 3) begin failures++; $display("FAIL abort_next_ack got=%0d want=3", obs_ack); end
    checks++; if (obs_rd !== 32'hA002_0002) begin failures++; $display("FAIL abort_next_data got=%0h want=a0020002", obs_rd); end
    a_idle(1);
  endtask

  task automatic test_back_to_back();
    logic        we  [8] = '{1, 1, 0, 1, 0, 0, 1, 0};
    logic [31:0] adr [8] = '{32'h8000_0010, 32'h8000_0414, 32'h8000_0414, 32'h8000_0BFC,
                             32'h8000_0C20, 32'h8000_0010, 32'h8000_0C24, 32'h8000_0BFC};
    logic [31:0] wd  [8] = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h5555_AAAA,
                             32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0};
    logic [3:0]  sel [8] = '{4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 4'hF};
    logic [31:0] exp [8] = '{32'h0, 32'h0, 32'hA001_0002, 32'h0,
                             32'hA003_0008, 32'hCAFE_0001, 32'h0, 32'h5555_AAAA};
    logic [3:0]  ecsb;
    for (int i = 0; i < 8; i++) begin
      a_xfer(we[i], adr[i], wd[i], sel[i]);
      ecsb = 4'hF ^ (4'b0001 << adr[i][11:10]);
      checks++; if (obs_ack !== (we[i] ? 2 : 3)) begin failures++; $display("FAIL b2b_ack_cycle[%0d] got=%0d want=%0d", i, obs_ack, we[i] ? 2 : 3); end
      checks++; if (obs_csb !== ecsb || obs_maxrun !== 1) begin failures++; $display("FAIL b2b_csb[%0d] got=%0b/run%0d want=%0b/run1", i, obs_csb, obs_maxrun, ecsb); end
      if (!we[i]) begin
        checks++; if (obs_rd !== exp[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%0h want=%0h", i, obs_rd, exp[i]); end
      end
    end
    a_idle(2);
    checks++; if (obs_stray !== 0) begin failures++; $display("FAIL b2b_tail got=%0d want=0", obs_stray); end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 32'h8000_0C10; a_dat_w = 32'h1234_5678; a_sel = 4'hF;
    @(negedge clk);
    @(posedge clk); #1; rst = 1;
    @(negedge clk);
    checks++; if (a_csb !== 4'b0111) begin failures++; $display("FAIL ra_issue_csb got=%0b want=0111", a_csb); end
    @(posedge clk); #1; rst = 0; a_cyc = 0; a_stb = 0; a_we = 0;
    @(negedge clk);
    checks++; if (a_csb !== 4'hF || a_web !== 1'b1 || a_wmask !== 4'h0) begin failures++; $display("FAIL ra_ctl got=csb%0h web%0b wm%0h want=csbf web1 wm0", a_csb, a_web, a_wmask); end
    checks++; if (a_addr_w !== 32'h0 || a_din !== 32'h0) begin failures++; $display("FAIL ra_bus got=addr%0h din%0h want=0/0", a_addr, a_din); end
    checks++; if (a_dat_r !== 32'h0 || a_ack !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL ra_resp got=dat%0h ack%0b err%0b want=0", a_dat_r, a_ack, a_err); end
    obs_stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ack || a_err || a_csb != 4'hF) obs_stray++;
    end
    checks++; if (obs_stray !== 0) begin failures++; $display("FAIL ra_after got=%0d want=0", obs_stray); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_err_bank();
    test_read_lat3();
    test_abort_cyc();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
